// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding controller: tracks in-flight destinations from EX to WB and
// produces EX forwarding selects, the load-use stall, the branch flush and event counters.
module hazard_forward_unit #(
    parameter int unsigned NUM_STAGES     = 3,
    parameter int unsigned REG_ADDR_W     = 5,
    parameter int unsigned LOAD_FWD_STAGE = 2,
    parameter int unsigned FLUSH_STAGE    = 1,
    parameter int unsigned CNT_W          = 32,
    localparam int unsigned SEL_W         = $clog2(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_uses_rs1_i,
    input  logic                  id_uses_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_reg_write_i,
    input  logic                  id_is_load_i,
    input  logic                  branch_taken_i,
    output logic                  stall_o,
    output logic                  flush_o,
    output logic [SEL_W-1:0]      fwd_a_sel_o,
    output logic [SEL_W-1:0]      fwd_b_sel_o,
    output logic                  ex_valid_o,
    output logic [CNT_W-1:0]      stall_count_o,
    output logic [CNT_W-1:0]      flush_count_o
);

    logic [NUM_STAGES-1:0] vld_q, vld_d, wr_q, wr_d, ld_q, ld_d;
    logic [REG_ADDR_W-1:0] rd_q [NUM_STAGES];
    logic [REG_ADDR_W-1:0] rd_d [NUM_STAGES];
    logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
    logic                  ex_u1_q, ex_u1_d, ex_u2_q, ex_u2_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic                  stall_hit;
    logic                  take_id;

    // Load-use: a load too young to be forwardable when the ID instruction reaches EX.
    always_comb begin
        stall_hit = 1'b0;
        for (int j = 0; j < int'(NUM_STAGES); j++) begin
            if ((j + 1 < int'(LOAD_FWD_STAGE)) && vld_q[j] && ld_q[j] && wr_q[j] &&
                (rd_q[j] != '0) &&
                ((id_uses_rs1_i && (id_rs1_i == rd_q[j])) ||
                 (id_uses_rs2_i && (id_rs2_i == rd_q[j])))) begin
                stall_hit = 1'b1;
            end
        end
    end

    assign flush_o    = branch_taken_i && !reset;
    assign stall_o    = !reset && id_valid_i && stall_hit && !branch_taken_i;
    assign ex_valid_o = vld_q[0];

    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        fwd_a_sel_o = '0;
        fwd_b_sel_o = '0;
        if (!reset && vld_q[0]) begin
            for (int k = int'(NUM_STAGES) - 1; k >= 1; k--) begin
                if (vld_q[k] && wr_q[k] && (rd_q[k] != '0) &&
                    (!ld_q[k] || (k >= int'(LOAD_FWD_STAGE)))) begin
                    if (ex_u1_q && (ex_rs1_q == rd_q[k])) fwd_a_sel_o = SEL_W'(k);
                    if (ex_u2_q && (ex_rs2_q == rd_q[k])) fwd_b_sel_o = SEL_W'(k);
                end
            end
        end
    end

    always_comb begin
        take_id  = id_valid_i && !stall_o && !flush_o;
        vld_d[0] = take_id;
        wr_d[0]  = take_id && id_reg_write_i;
        ld_d[0]  = take_id && id_is_load_i;
        rd_d[0]  = take_id ? id_rd_i : '0;
        ex_rs1_d = take_id ? id_rs1_i : '0;
        ex_rs2_d = take_id ? id_rs2_i : '0;
        ex_u1_d  = take_id && id_uses_rs1_i;
        ex_u2_d  = take_id && id_uses_rs2_i;
        for (int k = 1; k < int'(NUM_STAGES); k++) begin
            vld_d[k] = vld_q[k-1];
            wr_d[k]  = wr_q[k-1];
            ld_d[k]  = ld_q[k-1];
            rd_d[k]  = rd_q[k-1];
            // Whatever shifts into entries up to the resolving stage is younger than the branch.
            if (flush_o && (k <= int'(FLUSH_STAGE))) begin
                vld_d[k] = 1'b0;
                wr_d[k]  = 1'b0;
                ld_d[k]  = 1'b0;
                rd_d[k]  = '0;
            end
        end
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_o && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_o && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q       <= '0;
            wr_q        <= '0;
            ld_q        <= '0;
            for (int k = 0; k < int'(NUM_STAGES); k++) rd_q[k] <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            ex_u1_q     <= 1'b0;
            ex_u2_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            vld_q       <= vld_d;
            wr_q        <= wr_d;
            ld_q        <= ld_d;
            for (int k = 0; k < int'(NUM_STAGES); k++) rd_q[k] <= rd_d[k];
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            ex_u1_q     <= ex_u1_d;
            ex_u2_q     <= ex_u2_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count_o = stall_cnt_q;
    assign flush_count_o = flush_cnt_q;

endmodule
